// File: rtl/gfx_fb_swap_ctrl_if.sv
// Signal bundle between the renderer/scanout side and the framebuffer swap controller.
// The controller connects through the slave modport.
interface gfx_fb_swap_ctrl_if #(
   parameter int NUM_BUFS = 2,
   parameter int CNT_BITS = 16
);
   localparam int BUF_BITS = ($clog2(NUM_BUFS) > 1) ? $clog2(NUM_BUFS) : 1;

   logic                gfx_last;
   logic                vga_vsync;
   logic                vsync_mode;
   logic [BUF_BITS-1:0] wr_buf;
   logic [BUF_BITS-1:0] rd_buf;
   logic                gfx_restart;
   logic                vga_enable;
   logic                frame_pending;
   logic [CNT_BITS-1:0] frames_shown;
   logic [CNT_BITS-1:0] frames_dropped;

   modport master (
      output gfx_last, vga_vsync, vsync_mode,
      input  wr_buf, rd_buf, gfx_restart, vga_enable, frame_pending,
             frames_shown, frames_dropped
   );

   modport slave (
      input  gfx_last, vga_vsync, vsync_mode,
      output wr_buf, rd_buf, gfx_restart, vga_enable, frame_pending,
             frames_shown, frames_dropped
   );
endinterface

// File: rtl/gfx_fb_swap_ctrl.sv
// N-buffer framebuffer swap controller: flushes each finished frame, then swaps the
// scanout buffer at vsync falling edge or immediately, counting shown/dropped frames.
module gfx_fb_swap_ctrl #(
   parameter int NUM_BUFS     = 2,
   parameter int FLUSH_CYCLES = 8,
   parameter int CNT_BITS     = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   gfx_fb_swap_ctrl_if.slave bus
);
   localparam int         BUF_BITS   = ($clog2(NUM_BUFS) > 1) ? $clog2(NUM_BUFS) : 1;
   localparam logic [8:0] FLUSH_LOAD = 9'(FLUSH_CYCLES + 1);
   localparam bit         TWO_BUFS   = (NUM_BUFS == 2);

   typedef enum logic [1:0] {INIT, RUN_IDLE, RUN_PENDING} state_t;

   state_t              state, state_nx;
   logic [8:0]          flush_cnt;
   logic                vsync_prev;
   logic [BUF_BITS-1:0] rd_buf, wr_buf, ready_buf;
   logic [BUF_BITS-1:0] rd_nx, wr_nx, ready_nx;
   logic                gfx_restart, restart_nx;
   logic [CNT_BITS-1:0] shown, dropped, shown_nx, dropped_nx;
   logic                complete, vsync_fall, flush_start;

   // Lowest buffer index that is neither being displayed nor holding the ready frame.
   function automatic logic [BUF_BITS-1:0] pick_free(input logic [BUF_BITS-1:0] a,
                                                     input logic [BUF_BITS-1:0] b);
      logic [BUF_BITS-1:0] idx;
      pick_free = '0;
      for (int i = NUM_BUFS - 1; i >= 0; i--) begin
         idx = BUF_BITS'(i);
         if (idx != a && idx != b) pick_free = idx;
      end
   endfunction

   // Counter idles at 0; loading FLUSH_CYCLES+1 makes completion land FLUSH_CYCLES+1 edges later.
   assign complete    = (flush_cnt == 9'd1);
   assign vsync_fall  = vsync_prev && !bus.vga_vsync && (state != INIT);
   assign flush_start = bus.gfx_last && (flush_cnt == '0) && !(TWO_BUFS && state == RUN_PENDING);

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      if (!reset_n) begin
         flush_cnt  <= '0;
         vsync_prev <= 1'b0;
      end else begin
         vsync_prev <= bus.vga_vsync;
         if (flush_start)          flush_cnt <= FLUSH_LOAD;
         else if (flush_cnt != '0) flush_cnt <= flush_cnt - 9'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= INIT;
         rd_buf      <= '0;
         wr_buf      <= '0;
         ready_buf   <= '0;
         gfx_restart <= 1'b0;
         shown       <= '0;
         dropped     <= '0;
      end else begin
         state       <= state_nx;
         rd_buf      <= rd_nx;
         wr_buf      <= wr_nx;
         ready_buf   <= ready_nx;
         gfx_restart <= restart_nx;
         shown       <= shown_nx;
         dropped     <= dropped_nx;
      end
   end

   // Vsync swap first on pre-cycle state; completion then sees the post-swap rd/state.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      state_nx   = state;
      rd_nx      = rd_buf;
      wr_nx      = wr_buf;
      ready_nx   = ready_buf;
      restart_nx = 1'b0;
      shown_nx   = shown;
      dropped_nx = dropped;

      if (vsync_fall && state == RUN_PENDING) begin
         rd_nx    = ready_buf;
         shown_nx = shown + 1'b1;
         state_nx = RUN_IDLE;
         if (TWO_BUFS) begin
            wr_nx      = rd_buf;
            restart_nx = 1'b1;
         end
      end

      if (complete) begin
         case (state_nx)
            INIT: begin
               rd_nx      = wr_buf;
               wr_nx      = BUF_BITS'(1);
               restart_nx = 1'b1;
               state_nx   = RUN_IDLE;
            end
            RUN_IDLE: begin
               if (!bus.vsync_mode) begin
                  wr_nx      = rd_nx;
                  rd_nx      = wr_buf;
                  shown_nx   = shown_nx + 1'b1;
                  restart_nx = 1'b1;
               end else begin
                  ready_nx = wr_buf;
                  state_nx = RUN_PENDING;
                  if (!TWO_BUFS) begin
                     wr_nx      = pick_free(rd_nx, wr_buf);
                     restart_nx = 1'b1;
                  end
               end
            end
            RUN_PENDING: begin
               dropped_nx = dropped + 1'b1;
               ready_nx   = wr_buf;
               wr_nx      = pick_free(rd_nx, wr_buf);
               restart_nx = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.wr_buf         = wr_buf;
   assign bus.rd_buf         = rd_buf;
   assign bus.gfx_restart    = gfx_restart;
   assign bus.vga_enable     = (state != INIT);
   assign bus.frame_pending  = (state == RUN_PENDING);
   assign bus.frames_shown   = shown;
   assign bus.frames_dropped = dropped;
endmodule

// File: tb/tb_gfx_fb_swap_ctrl.sv
// Directed bench: a double-buffer and a triple-buffer instance, FLUSH_CYCLES=8,
// driven through init, vsync swaps, drops, tearing mode, same-cycle events and reset.
`timescale 1ns/1ps
module tb_gfx_fb_swap_ctrl;
   logic clk;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   gfx_fb_swap_ctrl_if #(.NUM_BUFS(2), .CNT_BITS(16)) b2 ();
   gfx_fb_swap_ctrl_if #(.NUM_BUFS(3), .CNT_BITS(16)) b3 ();

   gfx_fb_swap_ctrl #(.NUM_BUFS(2), .FLUSH_CYCLES(8), .CNT_BITS(16)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(b2.slave));
   gfx_fb_swap_ctrl #(.NUM_BUFS(3), .FLUSH_CYCLES(8), .CNT_BITS(16)) dut3 (
      .clk(clk), .reset_n(reset_n), .bus(b3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " b2 wr"},      b2.wr_buf,         0);
      chk({tag, " b2 rd"},      b2.rd_buf,         0);
      chk({tag, " b2 restart"}, b2.gfx_restart,    0);
      chk({tag, " b2 enable"},  b2.vga_enable,     0);
      chk({tag, " b2 pending"}, b2.frame_pending,  0);
      chk({tag, " b2 shown"},   b2.frames_shown,   0);
      chk({tag, " b2 dropped"}, b2.frames_dropped, 0);
      chk({tag, " b3 wr"},      b3.wr_buf,         0);
      chk({tag, " b3 rd"},      b3.rd_buf,         0);
      chk({tag, " b3 enable"},  b3.vga_enable,     0);
      chk({tag, " b3 shown"},   b3.frames_shown,   0);
      chk({tag, " b3 dropped"}, b3.frames_dropped, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      b2.gfx_last = 0; b2.vga_vsync = 0; b2.vsync_mode = 0;
      b3.gfx_last = 0; b3.vga_vsync = 0; b3.vsync_mode = 0;
      tick(3);
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick(2);

      // INIT completion on both instances: visible 9 edges after the sampling edge
      b2.gfx_last = 1; b3.gfx_last = 1;
      tick(1);
      b2.gfx_last = 0; b3.gfx_last = 0;
      tick(8);
      chk("init early enable", b2.vga_enable, 0);
      tick(1);
      chk("init enable",  b2.vga_enable,   1);
      chk("init rd",      b2.rd_buf,       0);
      chk("init wr",      b2.wr_buf,       1);
      chk("init restart", b2.gfx_restart,  1);
      chk("init shown",   b2.frames_shown, 0);
      chk("init b3 wr",   b3.wr_buf,       1);
      chk("init b3 en",   b3.vga_enable,   1);
      tick(1);
      chk("init restart one cycle", b2.gfx_restart, 0);

      // Double buffer, vsync mode: frame waits, renderer idles, swap on falling edge
      b2.vsync_mode = 1; b3.vsync_mode = 1;
      b2.gfx_last = 1;
      tick(1);
      b2.gfx_last = 0;
      tick(8);
      chk("vs2 early pending", b2.frame_pending, 0);
      tick(1);
      chk("vs2 pending",    b2.frame_pending, 1);
      chk("vs2 no restart", b2.gfx_restart,   0);
      chk("vs2 rd held",    b2.rd_buf,        0);
      b2.gfx_last = 1;
      tick(1);
      b2.gfx_last = 0;
      tick(12);
      chk("vs2 ignored last", b2.frame_pending, 1);
      chk("vs2 ignored wr",   b2.wr_buf,        1);
      b2.vga_vsync = 1;
      tick(1);
      b2.vga_vsync = 0;
      tick(1);
      chk("vs2 swap rd",      b2.rd_buf,        1);
      chk("vs2 swap wr",      b2.wr_buf,        0);
      chk("vs2 swap restart", b2.gfx_restart,   1);
      chk("vs2 swap shown",   b2.frames_shown,  1);
      chk("vs2 swap pending", b2.frame_pending, 0);

      // Triple buffer: two completions without vsync drop the older frame
      b3.gfx_last = 1;
      tick(1);
      b3.gfx_last = 0;
      tick(9);
      chk("tb3 c1 pending", b3.frame_pending, 1);
      chk("tb3 c1 wr",      b3.wr_buf,        2);
      chk("tb3 c1 restart", b3.gfx_restart,   1);
      chk("tb3 c1 rd",      b3.rd_buf,        0);
      b3.gfx_last = 1;
      tick(1);
      b3.gfx_last = 0;
      tick(9);
      chk("tb3 c2 dropped", b3.frames_dropped, 1);
      chk("tb3 c2 wr",      b3.wr_buf,         1);
      chk("tb3 c2 restart", b3.gfx_restart,    1);
      chk("tb3 c2 pending", b3.frame_pending,  1);
      b3.vga_vsync = 1;
      tick(1);
      b3.vga_vsync = 0;
      tick(1);
      chk("tb3 vs rd",      b3.rd_buf,        2);
      chk("tb3 vs wr",      b3.wr_buf,        1);
      chk("tb3 vs shown",   b3.frames_shown,  1);
      chk("tb3 vs pending", b3.frame_pending, 0);
      chk("tb3 vs restart", b3.gfx_restart,   0);

      // Double buffer, tearing mode: swap exactly 9 edges after each gfx_last
      b2.vsync_mode = 0;
      b2.gfx_last = 1; tick(1); b2.gfx_last = 0; tick(8);
      chk("tear f1 early rd", b2.rd_buf, 1);
      tick(1);
      chk("tear f1 rd", b2.rd_buf, 0);
      chk("tear f1 wr", b2.wr_buf, 1);
      b2.gfx_last = 1; tick(1); b2.gfx_last = 0; tick(9);
      chk("tear f2 rd", b2.rd_buf, 1);
      chk("tear f2 wr", b2.wr_buf, 0);
      b2.gfx_last = 1; tick(1); b2.gfx_last = 0; tick(9);
      chk("tear f3 rd",    b2.rd_buf,       0);
      chk("tear f3 shown", b2.frames_shown, 4);
      b2.vga_vsync = 1; tick(1); b2.vga_vsync = 0; tick(2);
      chk("tear vs rd",    b2.rd_buf,       0);
      chk("tear vs wr",    b2.wr_buf,       1);
      chk("tear vs shown", b2.frames_shown, 4);

      // Triple buffer: completion and vsync falling edge on the same edge
      b3.gfx_last = 1; tick(1); b3.gfx_last = 0; tick(9);
      chk("sim pre pending", b3.frame_pending, 1);
      chk("sim pre wr",      b3.wr_buf,        0);
      b3.gfx_last = 1; tick(1); b3.gfx_last = 0; tick(7);
      b3.vga_vsync = 1; tick(1);
      chk("sim e8 rd", b3.rd_buf, 2);
      b3.vga_vsync = 0; tick(1);
      chk("sim rd",      b3.rd_buf,         1);
      chk("sim wr",      b3.wr_buf,         2);
      chk("sim pending", b3.frame_pending,  1);
      chk("sim dropped", b3.frames_dropped, 1);
      chk("sim shown",   b3.frames_shown,   2);
      chk("sim restart", b3.gfx_restart,    1);
      b3.vga_vsync = 1; tick(1); b3.vga_vsync = 0; tick(1);
      chk("sim next rd",    b3.rd_buf,       0);
      chk("sim next shown", b3.frames_shown, 3);

      // Asynchronous reset mid-flush, then a clean INIT sequence
      b2.gfx_last = 1; tick(1); b2.gfx_last = 0; tick(4);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("async reset");
      tick(2);
      reset_n = 1'b1;
      tick(3);
      b2.gfx_last = 1; tick(1); b2.gfx_last = 0; tick(8);
      chk("rst init early enable", b2.vga_enable, 0);
      tick(1);
      chk("rst init enable",  b2.vga_enable,  1);
      chk("rst init rd",      b2.rd_buf,      0);
      chk("rst init wr",      b2.wr_buf,      1);
      chk("rst init restart", b2.gfx_restart, 1);
      tick(1);
      chk("rst init restart end", b2.gfx_restart, 0);
      chk("rst b3 idle", b3.vga_enable, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
